// File: rtl/fetch_queue.sv
// Instruction buffer between IF and PD: DEPTH-entry FIFO of {pc, ir, pr_taken}.
// An empty queue presents a NOP at the head; a flush empties it in one edge.
module fetch_queue #(
    parameter int              DEPTH = 4,
    parameter int              XLEN  = 64,
    parameter int              ILEN  = 32,
    parameter logic [ILEN-1:0] NOP   = ILEN'(32'h13)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_n,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [ILEN-1:0]          in_ir,
    input  logic                     in_pr_taken,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_pc,
    output logic [ILEN-1:0]          out_ir,
    output logic                     out_pr_taken,
    input  logic                     out_pop,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc_mem [DEPTH];
    logic [ILEN-1:0] ir_mem [DEPTH];
    logic            pr_mem [DEPTH];

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;

    // Full is decided by count alone, so in_ready never depends on out_pop.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_pop & out_valid;
    assign count     = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
        end else if (!flush_n) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is deliberately not reset; the empty-case forcing below hides stale data.
    always_ff @(posedge clk) begin
        if (push && flush_n) begin
            pc_mem[wp] <= in_pc;
            ir_mem[wp] <= in_ir;
            pr_mem[wp] <= in_pr_taken;
        end
    end

    always_comb begin
        out_pc       = '0;
        out_ir       = NOP;
        out_pr_taken = 1'b0;
        if (out_valid) begin
            out_pc       = pc_mem[rp];
            out_ir       = ir_mem[rp];
            out_pr_taken = pr_mem[rp];
        end
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction buffer between the IF stage (PC/L1i/BPU) and the PD stage of the hart. It replaces the fixed single-entry IF→PD register with a DEPTH-entry FIFO, so fetch can keep running while downstream is stalled. Each entry carries PC, instruction word and the BPU prediction bit. Misprediction and JALR flushes empty the queue in one cycle, and the empty queue presents a NOP to the predecoder.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- XLEN, 64, PC width
- ILEN, 32, instruction width
- NOP, 32'h13, instruction word presented when empty (addi x0,x0,0)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush_n  in  1  synchronous flush, active-low (driven by rst_n & !pr_miss & !jalr_taken)
- in_valid  in  1  IF presents a fetched instruction
- in_pc  in  XLEN  PC of fetched instruction
- in_ir  in  ILEN  fetched instruction
- in_pr_taken  in  1  BPU predicted-taken flag for in_pc
- in_ready  out  1  queue can accept; drives stall_if = !in_ready
- out_valid  out  1  head entry holds a real instruction
- out_pc  out  XLEN  head PC
- out_ir  out  ILEN  head instruction
- out_pr_taken  out  1  head prediction flag
- out_pop  in  1  PD consumes head this cycle (= !stall_pd)
- count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH

## Operation
- Storage: DEPTH-entry array of {pc, ir, pr_taken}. Write pointer wp, read pointer rp, each $clog2(DEPTH) bits, plus count register.
- Push: in_valid & in_ready. Entry written at wp, wp increments modulo DEPTH.
- Pop: out_pop & out_valid. rp increments modulo DEPTH. out_pop while empty is ignored; it is not an error.
- count' = count + push − pop. Push and pop in the same cycle leave count unchanged and advance both pointers.
- in_ready = (count != DEPTH). A full queue rejects pushes even when a pop occurs in the same cycle. This gives a single-cycle bubble at full and keeps in_ready free of any combinational dependence on out_pop.
- out_valid = (count != 0).
- Outputs when non-empty: out_pc, out_ir and out_pr_taken are the entry at rp, combinational from registers.
- Outputs when empty: out_ir = NOP, out_pr_taken = 0, out_pc = 0.
- No fall-through: an instruction pushed into an empty queue is not visible on out_* in the same cycle.
- Flush (flush_n=0): at the edge, wp, rp and count go to 0. Flush has priority over a simultaneous push or pop, so both are discarded. in_ready is 1 on the cycle after a flush.
- Storage array is not reset and not cleared by flush. Outputs must never expose stale entries: the empty-case forcing above guarantees this.
- Pointer wrap: wp and rp wrap DEPTH−1 → 0. Full and empty are distinguished only by count, never by pointer equality.
- Reset (rst_n=0, asynchronous): wp=0, rp=0, count=0, effective immediately. Reset values of every output:
  - in_ready=1, out_valid=0, out_ir=NOP, out_pr_taken=0, out_pc=0, count=0.
  - Reset asserted mid-operation discards all entries regardless of in-flight push or pop.

## Timing
- Push-to-head latency: 1 cycle. An entry written at edge N appears on out_* after edge N when it is the oldest entry.
- Pop takes effect at the edge. The next entry, or NOP if the queue becomes empty, is presented after that edge.
- in_ready, out_valid and count all change only on clk edges or on async reset.
- Handshake: IF holds in_pc/in_ir/in_pr_taken stable while in_valid & !in_ready.
- Flush latency: 1 edge. After the flushing edge, out_ir=NOP and out_valid=0.
- Throughput: 1 push and 1 pop per cycle when 0 < count < DEPTH.

## Test plan
- Reset: drive rst_n=0 asynchronously mid-cycle after pushing 3 entries -> immediately count=0, out_valid=0, out_ir=32'h13, in_ready=1.
- Fill/drain (DEPTH=4): push PCs 0x100,0x104,0x108,0x10C with out_pop=0 -> count=4, in_ready=0. A 5th push (0x110) held by IF is not accepted. Then pop 4 times -> out_pc sequence 0x100,0x104,0x108,0x10C, then out_ir=0x13, out_valid=0.
- Full with simultaneous push+pop: count=4, in_valid=1, out_pop=1 -> next count=3, the pushed entry is not stored, and the head advances to 0x104.
- Wrap-around: 10 cycles of continuous push+pop from count=1 with PCs incrementing by 4 -> count stays 1 and out_pc tracks in_pc delayed by the cycles of occupancy, with no entry lost across the pointer wrap at 3→0.
- Flush: count=3, pr_taken set on the head, flush_n=0 with in_valid=1 and out_pop=1 in the same cycle -> next count=0, out_ir=0x13, out_pr_taken=0, out_valid=0. The next push (pc 0x200) appears at the head one cycle later.
- Empty pop: count=0, out_pop=1, in_valid=1 (pc 0x300) -> count=1, out_pc=0x300 after the edge, and no pointer underflow.
